ioblock_bank: RTL and testbench



---
 rtl/ioblock_pkg.sv | 24 ++
 rtl/ioblock_pin.sv | 63 ++++++
 rtl/ioblock_bank.sv | 116 +++++++++++
 tb/tb_ioblock_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioblock_pkg.sv
// ioblock_pkg: shared constants and types for the IO bank.
//   - CFG_PER_PIN and the per-pin configuration field offsets
//   - TSMUX encodings for the tristate select field
//   - state type of the configuration load FSM
package ioblock_pkg;

  localparam int CFG_PER_PIN   = 4;
  localparam int CFG_TSMUX_LSB = 0;
  localparam int CFG_DORREG    = 2;
  localparam int CFG_OREG      = 3;

  // 2'b11 is not named: it behaves like TS_ON (always drive).
  localparam logic [1:0] TS_OFF  = 2'b00;
  localparam logic [1:0] TS_CTRL = 2'b01;
  localparam logic [1:0] TS_ON   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    OVER  = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/ioblock_pin.sv
// ioblock_pin: datapath of one IO cell.
// Ports:
//   i_clk, i_rst : bank IO clock, async active-high reset
//   i_cfg        : 4-bit active config {OREG, DORREG, TSMUX[1:0]}
//   i_ts, i_out  : tristate enable (1 = drive) and output data from fabric
//   i_pad        : value currently seen on the pad
//   o_in         : input data to fabric
//   o_oe, o_do   : pad drive enable and drive value (the top builds the tristate)
import ioblock_pkg::*;

module ioblock_pin (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [CFG_PER_PIN-1:0] i_cfg,
  input  logic                   i_ts,
  input  logic                   i_out,
  input  logic                   i_pad,
  output logic                   o_in,
  output logic                   o_oe,
  output logic                   o_do
);

  logic       r_d;
  logic       r_oq;
  logic       r_tq;
  logic [1:0] w_tsmux;
  logic       w_oreg;
  logic       w_dorreg;
  logic       w_ts_eff;

  // The staging registers run every cycle regardless of mode, so switching
  // OREG/DORREG selects an already-settled value and never glitches state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d  <= 1'b0;
      r_oq <= 1'b0;
      r_tq <= 1'b0;
    end else begin
      r_d  <= i_pad;
      r_oq <= i_out;
      r_tq <= i_ts;
    end
  end

  assign w_tsmux  = i_cfg[CFG_TSMUX_LSB +: 2];
  assign w_oreg   = i_cfg[CFG_OREG];
  assign w_dorreg = i_cfg[CFG_DORREG];

  // TS and data share the same staging choice so they stay aligned.
  assign w_ts_eff = w_oreg ? r_tq : i_ts;
  assign o_do     = w_oreg ? r_oq : i_out;
  assign o_in     = w_dorreg ? r_d : i_pad;

  always_comb begin
    o_oe = 1'b0;
    case (w_tsmux)
      TS_OFF:  o_oe = 1'b0;
      TS_CTRL: o_oe = w_ts_eff;
      default: o_oe = 1'b1;
    endcase
  end

endmodule

// File: rtl/ioblock_bank.sv
// ioblock_bank: bank of NPINS configurable bidirectional IO cells.
// Ports:
//   IOCLK, RST   : bank IO clock, async active-high reset
//   PIN          : pad pins (inout)
//   TS, OUT, IN  : per-pin tristate enable, output data, input data
//   CFG_SI/CFG_SO: serial config chain in / out (out = shadow MSB)
//   CFG_EN       : shift enable for the shadow chain
//   CFG_LOAD     : commit request, shadow -> active
//   CFG_READY    : exactly 4*NPINS bits shifted since last load/reset
//   CFG_ERR      : sticky, set by a commit attempt when not ready
//   o_dbg_state  : config FSM state (debug)
//   o_dbg_cnt    : shift counter (debug)
// Load handshake: CFG_LOAD is a single-cycle request that is always consumed
// on the edge it is seen; it commits only if CFG_READY is high in that same
// cycle, otherwise it sets CFG_ERR. Either way the counter restarts at IDLE.
import ioblock_pkg::*;

module ioblock_bank #(
  parameter int                         NPINS    = 8,
  parameter logic [4*NPINS-1:0]         INIT_CFG = '0
) (
  input  logic                                IOCLK,
  input  logic                                RST,
  inout  wire  [NPINS-1:0]                    PIN,
  input  logic [NPINS-1:0]                    TS,
  input  logic [NPINS-1:0]                    OUT,
  output logic [NPINS-1:0]                    IN,
  input  logic                                CFG_SI,
  input  logic                                CFG_EN,
  input  logic                                CFG_LOAD,
  output logic                                CFG_SO,
  output logic                                CFG_READY,
  output logic                                CFG_ERR,
  output logic [1:0]                          o_dbg_state,
  output logic [$clog2(CFG_PER_PIN*NPINS+1)-1:0] o_dbg_cnt
);

  localparam int                SW      = CFG_PER_PIN * NPINS;
  localparam int                CNT_W   = $clog2(SW + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SW);

  logic [SW-1:0]    r_shadow;
  logic [SW-1:0]    r_active;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  cfg_state_e       r_state;

  cfg_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_shift;
  logic             w_commit;
  logic [NPINS-1:0] w_oe;
  logic [NPINS-1:0] w_do;

  // A load in the same cycle as a shift wins and discards the shift.
  assign w_shift = CFG_EN & ~CFG_LOAD;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (CFG_LOAD) begin
      w_commit    = (r_state == FULL);
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_shift) begin
      case (r_state)
        IDLE, SHIFT: begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = (w_cnt_nxt == CNT_MAX) ? FULL : SHIFT;
        end
        // Counter is already saturated at CNT_MAX here.
        FULL:    w_state_nxt = OVER;
        default: w_state_nxt = OVER;
      endcase
    end
  end

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= INIT_CFG;
      r_active <= INIT_CFG;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_shift)  r_shadow <= {r_shadow[SW-2:0], CFG_SI};
      if (w_commit) r_active <= r_shadow;
      if (CFG_LOAD) r_err    <= ~w_commit;
    end
  end

  assign CFG_SO      = r_shadow[SW-1];
  assign CFG_READY   = (r_state == FULL);
  assign CFG_ERR     = r_err;
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

  for (genvar k = 0; k < NPINS; k++) begin : g_pin
    ioblock_pin u_pin (
      .i_clk (IOCLK),
      .i_rst (RST),
      .i_cfg (r_active[CFG_PER_PIN*k +: CFG_PER_PIN]),
      .i_ts  (TS[k]),
      .i_out (OUT[k]),
      .i_pad (PIN[k]),
      .o_in  (IN[k]),
      .o_oe  (w_oe[k]),
      .o_do  (w_do[k])
    );
    assign PIN[k] = w_oe[k] ? w_do[k] : 1'bz;
  end

endmodule

// File: tb/tb_ioblock_bank.sv
// tb_ioblock_bank: directed, table-driven bench for ioblock_bank (NPINS=8).
// Undriven pads are observed by driving them from the bench with a value
// opposite to what the DUT would drive and checking the bench value wins.
module tb_ioblock_bank;

  logic       clk;
  logic       rst;
  logic [7:0] ts;
  logic [7:0] out_d;
  wire  [7:0] in_d;
  wire  [7:0] pin;
  logic       cfg_si;
  logic       cfg_en;
  logic       cfg_load;
  wire        cfg_so;
  wire        cfg_ready;
  wire        cfg_err;
  wire  [1:0] dbg_state;
  wire  [5:0] dbg_cnt;
  logic [7:0] ext_en;
  logic [7:0] ext_val;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] cfg;
    logic       ts;
    logic       out;
    logic       ext_en;
    logic       ext_val;
    logic       do_tick;
    logic       exp_pin;
    logic       exp_in;
  } vec_t;

  vec_t vecs[9];

  ioblock_bank #(.NPINS(8)) dut (
    .IOCLK       (clk),
    .RST         (rst),
    .PIN         (pin),
    .TS          (ts),
    .OUT         (out_d),
    .IN          (in_d),
    .CFG_SI      (cfg_si),
    .CFG_EN      (cfg_en),
    .CFG_LOAD    (cfg_load),
    .CFG_SO      (cfg_so),
    .CFG_READY   (cfg_ready),
    .CFG_ERR     (cfg_err),
    .o_dbg_state (dbg_state),
    .o_dbg_cnt   (dbg_cnt)
  );

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pin[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_si = w[i];
      cfg_en = 1'b1;
      tick();
    end
    cfg_en = 1'b0;
    cfg_si = 1'b0;
  endtask

  task automatic pulse_load();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] w);
    shift_bits({32'h0, w}, 32);
    pulse_load();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // {cfg, ts, out, ext_en, ext_val, tick, exp_pin, exp_in} for pin 0
    vecs[0] = '{4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // TS_ON comb
    vecs[1] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // TS_CTRL drive
    vecs[3] = '{4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // TS_CTRL Z
    vecs[4] = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // TS_OFF Z
    vecs[5] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // 11 = drive
    vecs[7] = '{4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}; // OREG drive
    vecs[8] = '{4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // OREG Z

    // reset state with an external driver on every pad
    rst      = 1'b1;
    cfg_si   = 1'b0;
    cfg_en   = 1'b0;
    cfg_load = 1'b0;
    ts       = 8'hFF;
    out_d    = 8'hFF;
    ext_en   = 8'hFF;
    ext_val  = 8'hA5;
    #3;
    chk("rst_pin", pin, 8'hA5);
    chk("rst_in", in_d, 8'hA5);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_cnt", dbg_cnt, 6'd0);
    tick();
    tick();
    rst     = 1'b0;
    ts      = 8'h00;
    out_d   = 8'h00;
    ext_en  = 8'h00;
    ext_val = 8'h00;
    tick();

    // table: pin 0 modes
    for (int i = 0; i < 9; i++) begin
      load_cfg({28'h0, vecs[i].cfg});
      ts[0]      = vecs[i].ts;
      out_d[0]   = vecs[i].out;
      ext_en[0]  = vecs[i].ext_en;
      ext_val[0] = vecs[i].ext_val;
      if (vecs[i].do_tick) tick();
      else #1;
      chk($sformatf("vec%0d_pin", i), pin[0], vecs[i].exp_pin);
      chk($sformatf("vec%0d_in", i), in_d[0], vecs[i].exp_in);
      ext_en[0] = 1'b0;
    end

    // OREG latency on data and tristate
    ts[0]    = 1'b0;
    out_d[0] = 1'b0;
    load_cfg(32'h0000_0009);
    ts[0] = 1'b1;
    tick();
    out_d[0] = 1'b1;
    #1;
    chk("oreg_data_hold", pin[0], 1'b0);
    tick();
    chk("oreg_data_lat", pin[0], 1'b1);
    ts[0] = 1'b0;
    #1;
    chk("oreg_ts_hold", pin[0], 1'b1);
    tick();
    ext_en[0]  = 1'b1;
    ext_val[0] = 1'b0;
    #1;
    chk("oreg_ts_z", pin[0], 1'b0);
    ext_en[0] = 1'b0;

    // DORREG on pin 3
    ts    = 8'h00;
    out_d = 8'h00;
    load_cfg(32'h0000_4000);
    ext_en[3]  = 1'b1;
    ext_val[3] = 1'b0;
    tick();
    chk("dor_init", in_d[3], 1'b0);
    ext_val[3] = 1'b1;
    #1;
    chk("dor_hold", in_d[3], 1'b0);
    tick();
    chk("dor_lat", in_d[3], 1'b1);
    load_cfg(32'h0000_0000);
    ext_val[3] = 1'b0;
    #1;
    chk("dor_comb0", in_d[3], 1'b0);
    ext_val[3] = 1'b1;
    #1;
    chk("dor_comb1", in_d[3], 1'b1);
    ext_en[3] = 1'b0;

    // illegal commits and recovery
    load_cfg(32'h0000_0002);
    out_d[0] = 1'b1;
    #1;
    chk("pre_err_pin", pin[0], 1'b1);
    shift_bits(64'h0, 31);
    chk("s31_cnt", dbg_cnt, 6'd31);
    chk("s31_state", dbg_state, 2'd1);
    chk("s31_ready", cfg_ready, 1'b0);
    pulse_load();
    chk("l31_err", cfg_err, 1'b1);
    chk("l31_cnt", dbg_cnt, 6'd0);
    chk("l31_state", dbg_state, 2'd0);
    chk("l31_active_kept", pin[0], 1'b1);
    shift_bits(64'h0, 33);
    chk("s33_state", dbg_state, 2'd3);
    chk("s33_ready", cfg_ready, 1'b0);
    chk("s33_cnt", dbg_cnt, 6'd32);
    pulse_load();
    chk("l33_err", cfg_err, 1'b1);
    chk("l33_active_kept", pin[0], 1'b1);
    shift_bits(64'h1, 32);
    chk("s32_ready", cfg_ready, 1'b1);
    chk("s32_cnt", dbg_cnt, 6'd32);
    chk("s32_state", dbg_state, 2'd2);
    chk("s32_err_sticky", cfg_err, 1'b1);
    pulse_load();
    chk("l32_err", cfg_err, 1'b0);
    chk("l32_state", dbg_state, 2'd0);
    ts[0]      = 1'b0;
    ext_en[0]  = 1'b1;
    ext_val[0] = 1'b0;
    #1;
    chk("new_cfg_z", pin[0], 1'b0);
    ext_en[0] = 1'b0;
    ts[0]     = 1'b1;
    #1;
    chk("new_cfg_drive", pin[0], 1'b1);

    // async reset mid-shift with all pins driven
    ts    = 8'hFF;
    out_d = 8'hFF;
    load_cfg(32'h2222_2222);
    chk("all_drive", pin, 8'hFF);
    shift_bits(64'h0, 17);
    chk("mid_cnt", dbg_cnt, 6'd17);
    #2;
    rst     = 1'b1;
    ext_en  = 8'hFF;
    ext_val = 8'h00;
    #1;
    chk("arst_pins_z", pin, 8'h00);
    chk("arst_in", in_d, 8'h00);
    chk("arst_cnt", dbg_cnt, 6'd0);
    chk("arst_ready", cfg_ready, 1'b0);
    chk("arst_state", dbg_state, 2'd0);
    tick();
    rst    = 1'b0;
    ext_en = 8'h00;
    ts     = 8'h00;
    out_d  = 8'h00;
    tick();

    // CFG_EN together with CFG_LOAD in FULL
    shift_bits({32'h0, 32'h9000_0002}, 32);
    chk("full_ready", cfg_ready, 1'b1);
    chk("full_so", cfg_so, 1'b1);
    cfg_si   = 1'b0;
    cfg_en   = 1'b1;
    cfg_load = 1'b1;
    tick();
    cfg_en   = 1'b0;
    cfg_load = 1'b0;
    chk("enload_so", cfg_so, 1'b1);
    chk("enload_cnt", dbg_cnt, 6'd0);
    chk("enload_state", dbg_state, 2'd0);
    chk("enload_err", cfg_err, 1'b0);
    out_d[0] = 1'b1;
    #1;
    chk("enload_commit", pin[0], 1'b1);
    shift_bits(64'h0, 1);
    chk("so_readback", cfg_so, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
